temp_sample_ctrl: RTL

TEMP_SAMPLE_CTRL -- requirements
Module: temp_sample_ctrl

---
 rtl/temp_sample_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/temp_sample_ctrl.sv
// temp_sample_ctrl
//   Sequences temperature sampling: periodic or on-demand reads from a sensor
//   reader, hands each raw sample to an external combinational converter for
//   one cycle, registers the converted value and tracks signed raw min/max.
//   A change of the unit select between samples reconverts the stored raw
//   value without touching the sensor.
//
// Ports
//   clk, rst             system clock, async active-high reset
//   en                   level, enables periodic sampling
//   start                pulse, immediate sample request
//   c_f                  unit select (0 = degC, 1 = degF)
//   clr_minmax           pulse, clears min/max tracking
//   rd_req / rd_ack      handshake to sensor reader, rd_data valid with rd_ack
//   rd_data[12:0]        raw two's-complement sample, 1/16 degC per LSB
//   conv_tc, conv_cf     operand/unit to external converter (held outside CONV)
//   conv_tx10[16:0]      converter result
//   tx10, raw            last converted value / last raw sample
//   raw_min, raw_max     signed min/max of raw since reset or clear
//   valid                one-cycle pulse when tx10 updates
//   busy                 high outside IDLE/WAIT
//   err                  sticky ack-timeout flag
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | sampling disabled, period counter held at 0
// WAIT  | counting down the sample period
// REQ   | rd_req asserted, waiting for rd_ack or timeout
// CONV  | converter operands presented, result registered at end of cycle
// DONE  | valid pulse, return to WAIT/IDLE

module temp_sample_ctrl #(
    parameter int SAMPLE_PERIOD = 100_000_000,
    parameter int ACK_TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        start,
    input  logic        c_f,
    input  logic        clr_minmax,
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic [12:0] rd_data,
    output logic [12:0] conv_tc,
    output logic        conv_cf,
    input  logic [16:0] conv_tx10,
    output logic [16:0] tx10,
    output logic [12:0] raw,
    output logic [12:0] raw_min,
    output logic [12:0] raw_max,
    output logic        valid,
    output logic        busy,
    output logic        err
);

    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [PW-1:0] PER_TC = PW'(SAMPLE_PERIOD - 1);
    localparam logic [AW-1:0] ACK_TC = AW'(ACK_TIMEOUT - 1);

    // Empty-tracker values: largest positive / most negative 13-bit numbers,
    // so the first compare after reset or clear simply loads the sample.
    localparam logic [12:0] MIN_INIT = 13'h0FFF;
    localparam logic [12:0] MAX_INIT = 13'h1000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_REQ  = 3'd2,
        S_CONV = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [PW-1:0]  per_cnt;
    logic [AW-1:0]  ack_cnt;
    logic           unit;
    logic           captured;
    logic           reconv;
    logic           per_tc;
    logic           ack_tc;
    logic           unit_chg;
    logic           enter_reconv;

    assign per_tc       = (per_cnt == PER_TC);
    assign ack_tc       = (ack_cnt == ACK_TC);
    assign unit_chg     = captured && (c_f != unit);
    assign enter_reconv = (state == S_IDLE || state == S_WAIT) && (state_nxt == S_CONV);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start)         state_nxt = S_REQ;
                else if (unit_chg) state_nxt = S_CONV;
                else if (en)       state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // start and terminal count in the same cycle collapse into one REQ
                if (start)         state_nxt = S_REQ;
                else if (!en)      state_nxt = S_IDLE;
                else if (per_tc)   state_nxt = S_REQ;
                else if (unit_chg) state_nxt = S_CONV;
            end
            S_REQ: begin
                if (rd_ack)      state_nxt = S_CONV;
                else if (ack_tc) state_nxt = en ? S_WAIT : S_IDLE;
            end
            S_CONV: state_nxt = S_DONE;
            S_DONE: state_nxt = en ? S_WAIT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        rd_req = (state == S_REQ);
        valid  = (state == S_DONE);
        busy   = (state == S_REQ) || (state == S_CONV) || (state == S_DONE);
    end

    // Datapath, counters and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt  <= '0;
            ack_cnt  <= '0;
            unit     <= 1'b0;
            captured <= 1'b0;
            reconv   <= 1'b0;
            raw      <= '0;
            tx10     <= '0;
            conv_tc  <= '0;
            conv_cf  <= 1'b0;
            raw_min  <= MIN_INIT;
            raw_max  <= MAX_INIT;
            err      <= 1'b0;
        end else begin
            // Period counter restarts on every real sample so the period is
            // measured from the end of one sample to the next request. During
            // a reconvert it keeps running but parks at terminal count so the
            // pending sample fires on return to WAIT.
            if (state_nxt == S_IDLE || (state_nxt == S_REQ && state != S_REQ)) begin
                per_cnt <= '0;
            end else if (state == S_WAIT) begin
                per_cnt <= per_tc ? '0 : per_cnt + PW'(1);
            end else if (reconv && !per_tc) begin
                per_cnt <= per_cnt + PW'(1);
            end

            if (state == S_REQ && !ack_tc) begin
                ack_cnt <= ack_cnt + AW'(1);
            end else if (state != S_REQ) begin
                ack_cnt <= '0;
            end

            if (state_nxt == S_CONV) begin
                reconv <= enter_reconv;
            end else if (state_nxt != S_DONE) begin
                reconv <= 1'b0;
            end

            if (state == S_REQ && rd_ack) begin
                raw      <= rd_data;
                unit     <= c_f;
                captured <= 1'b1;
                conv_tc  <= rd_data;
                conv_cf  <= c_f;
            end else if (enter_reconv) begin
                unit    <= c_f;
                conv_tc <= raw;
                conv_cf <= c_f;
            end

            if (state == S_REQ && !rd_ack && ack_tc) begin
                err <= 1'b1;
            end

            if (state == S_CONV) begin
                tx10 <= conv_tx10;
                // A clear landing on the update cycle restarts tracking with
                // this sample.
                if (clr_minmax) begin
                    raw_min <= raw;
                    raw_max <= raw;
                end else begin
                    if ($signed(raw) < $signed(raw_min)) raw_min <= raw;
                    if ($signed(raw) > $signed(raw_max)) raw_max <= raw;
                end
            end else if (clr_minmax) begin
                raw_min <= MIN_INIT;
                raw_max <= MAX_INIT;
            end
        end
    end

endmodule
